// File: rtl/id_scoreboard_pkg.sv
// Shared types and constants for the decode-stage issue scoreboard.
package id_scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_SERW  = 2'd2
  } sb_state_e;

  localparam int unsigned STALL_SAT = 0;
  localparam int unsigned STALL_RAW = 1;
  localparam int unsigned STALL_SER = 2;
  localparam int unsigned STALL_NUM = 3;
  localparam int unsigned NREGS     = 32;

  // Only the highest-priority cause survives: ser > raw > sat.
  function automatic logic [STALL_NUM-1:0] stall_prio(input logic [STALL_NUM-1:0] c);
    stall_prio = '0;
    if (c[STALL_SER])      stall_prio[STALL_SER] = 1'b1;
    else if (c[STALL_RAW]) stall_prio[STALL_RAW] = 1'b1;
    else if (c[STALL_SAT]) stall_prio[STALL_SAT] = 1'b1;
  endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Decode / write-back side signals of the issue scoreboard.
interface id_scoreboard_if #(
  parameter int unsigned CNT_W = 2
);
  logic             id_valid;
  logic             rs1_r_ena;
  logic             rs2_r_ena;
  logic [4:0]       rs1_r_addr;
  logic [4:0]       rs2_r_addr;
  logic             rd_w_ena;
  logic [4:0]       rd_w_addr;
  logic             ser_inst;
  logic             ex_allowin;
  logic             id_flush;
  logic             flush_all;
  logic             wb_valid;
  logic             wb_rd_ena;
  logic [4:0]       wb_rd_addr;
  logic             id_ready_go;
  logic             issue;
  logic [CNT_W-1:0] inflight_cnt;
  logic             stall_raw;
  logic             stall_sat;
  logic             stall_ser;
  logic             sb_err;

  modport master (
    output id_valid, rs1_r_ena, rs2_r_ena, rs1_r_addr, rs2_r_addr, rd_w_ena, rd_w_addr,
           ser_inst, ex_allowin, id_flush, flush_all, wb_valid, wb_rd_ena, wb_rd_addr,
    input  id_ready_go, issue, inflight_cnt, stall_raw, stall_sat, stall_ser, sb_err
  );

  modport slave (
    input  id_valid, rs1_r_ena, rs2_r_ena, rs1_r_addr, rs2_r_addr, rd_w_ena, rd_w_addr,
           ser_inst, ex_allowin, id_flush, flush_all, wb_valid, wb_rd_ena, wb_rd_addr,
    output id_ready_go, issue, inflight_cnt, stall_raw, stall_sat, stall_ser, sb_err
  );
endinterface

// File: rtl/id_scoreboard_sb_pend_cnt.sv
// Saturating up/down pending counter; flags a decrement attempted at zero.
module sb_pend_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         underflow_o
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + ONE;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/id_scoreboard.sv
// Decode issue controller: RAW / saturation gating and CSR-style serialization.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic           clk,
  input  logic           rst,
  id_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] INFL_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]     pend [NREGS];
  logic [NREGS-1:0]     uflow;
  logic [CNT_W-1:0]     infl;
  logic                 infl_uflow;
  logic [STALL_NUM-1:0] cause, stall;
  logic                 ready_go, issue;
  sb_state_e            state_q;
  logic                 sb_err_q;

  assign pend[0]  = '0;
  assign uflow[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_pend
    logic [CNT_W-1:0] cnt;
    logic             inc, dec;
    assign inc = issue & sb.rd_w_ena & (sb.rd_w_addr == 5'(r));
    assign dec = sb.wb_valid & sb.wb_rd_ena & (sb.wb_rd_addr == 5'(r));
    sb_pend_cnt #(.W(CNT_W)) u_cnt (
      .clk_i(clk), .rst_ni(rst), .clr_i(sb.flush_all), .inc_i(inc), .dec_i(dec),
      .cnt_o(cnt), .underflow_o(uflow[r])
    );
    assign pend[r] = cnt;
  end

  sb_pend_cnt #(.W(CNT_W)) u_inflight (
    .clk_i(clk), .rst_ni(rst), .clr_i(sb.flush_all), .inc_i(issue), .dec_i(sb.wb_valid),
    .cnt_o(infl), .underflow_o(infl_uflow)
  );

  always_comb begin
    cause            = '0;
    cause[STALL_RAW] = (sb.rs1_r_ena && sb.rs1_r_addr != '0 && pend[sb.rs1_r_addr] != '0) ||
                       (sb.rs2_r_ena && sb.rs2_r_addr != '0 && pend[sb.rs2_r_addr] != '0);
    cause[STALL_SAT] = (sb.rd_w_ena && sb.rd_w_addr != '0 && pend[sb.rd_w_addr] == CNT_MAX) ||
                       (infl == INFL_MAX);
    case (state_q)
      SB_RUN:   cause[STALL_SER] = sb.id_valid && sb.ser_inst && infl != '0;
      SB_DRAIN: cause[STALL_SER] = infl != '0;
      default:  cause[STALL_SER] = 1'b1;
    endcase
  end

  assign stall    = stall_prio(cause);
  assign ready_go = ~|stall;
  assign issue    = sb.id_valid & ready_go & sb.ex_allowin & ~sb.id_flush & ~sb.flush_all;

  // SER_WAIT leaves on the edge that retires the last in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SB_RUN;
    end else if (sb.flush_all) begin
      state_q <= SB_RUN;
    end else begin
      case (state_q)
        SB_RUN: begin
          if (issue && sb.ser_inst)                    state_q <= SB_SERW;
          else if (cause[STALL_SER] && !sb.id_flush)   state_q <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (sb.id_flush)  state_q <= SB_RUN;
          else if (issue)   state_q <= SB_SERW;
        end
        SB_SERW: begin
          if (infl == '0 || (infl == ONE && sb.wb_valid)) state_q <= SB_RUN;
        end
        default: state_q <= SB_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_err_q <= 1'b0;
    else      sb_err_q <= sb_err_q | (|uflow) | infl_uflow;
  end

  assign sb.id_ready_go  = ready_go;
  assign sb.issue        = issue;
  assign sb.inflight_cnt = infl;
  assign sb.stall_ser    = stall[STALL_SER];
  assign sb.stall_raw    = stall[STALL_RAW];
  assign sb.stall_sat    = stall[STALL_SAT];
  assign sb.sb_err       = sb_err_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios plus a randomized run against a queue model.
module tb_id_scoreboard;
  logic clk, rst;
  int total = 0;
  int bad   = 0;

  id_scoreboard_if #(.CNT_W(2)) sb();
  id_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (.clk(clk), .rst(rst), .sb(sb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    sb.id_valid = 0; sb.rs1_r_ena = 0; sb.rs2_r_ena = 0; sb.rs1_r_addr = '0; sb.rs2_r_addr = '0;
    sb.rd_w_ena = 0; sb.rd_w_addr = '0; sb.ser_inst = 0; sb.ex_allowin = 1; sb.id_flush = 0;
    sb.flush_all = 0; sb.wb_valid = 0; sb.wb_rd_ena = 0; sb.wb_rd_addr = '0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic ser);
    sb.id_valid = 1; sb.rs1_r_ena = 1; sb.rs2_r_ena = 1; sb.rs1_r_addr = rs1; sb.rs2_r_addr = rs2;
    sb.rd_w_ena = 1; sb.rd_w_addr = rd; sb.ser_inst = ser;
  endtask

  task automatic set_wb(input logic v, input logic en, input logic [4:0] rd);
    sb.wb_valid = v; sb.wb_rd_ena = en; sb.wb_rd_addr = rd;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    @(negedge clk);
    instr(5'd1, 5'd2, 5'd3, 1'b0);
    #1;
    total++; if (sb.id_ready_go !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b exp=1", sb.id_ready_go); end
    total++; if (sb.issue !== 1'b1) begin bad++; $display("FAIL reset_issue: got=%b exp=1", sb.issue); end
    total++; if (sb.inflight_cnt !== 2'd0) begin bad++; $display("FAIL reset_inflight: got=%0d exp=0", sb.inflight_cnt); end
    total++; if ({sb.stall_ser, sb.stall_raw, sb.stall_sat} !== 3'b000) begin bad++; $display("FAIL reset_stalls: got=%b exp=000", {sb.stall_ser, sb.stall_raw, sb.stall_sat}); end
    total++; if (sb.sb_err !== 1'b0) begin bad++; $display("FAIL reset_err: got=%b exp=0", sb.sb_err); end
    @(negedge clk);
    rst = 1;
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    instr(5'd0, 5'd0, 5'd5, 1'b0); #1;
    total++; if (sb.issue !== 1'b1) begin bad++; $display("FAIL raw_producer_issue: got=%b exp=1", sb.issue); end
    @(negedge clk); instr(5'd5, 5'd7, 5'd6, 1'b0); #1;
    total++; if (sb.stall_raw !== 1'b1 || sb.issue !== 1'b0) begin bad++; $display("FAIL raw_consumer_stall: got raw=%b issue=%b exp raw=1 issue=0", sb.stall_raw, sb.issue); end
    repeat (2) begin
      @(negedge clk); #1;
      total++; if (sb.stall_raw !== 1'b1) begin bad++; $display("FAIL raw_hold: got=%b exp=1", sb.stall_raw); end
    end
    @(negedge clk); set_wb(1, 1, 5'd5); #1;
    total++; if (sb.stall_raw !== 1'b1 || sb.issue !== 1'b0) begin bad++; $display("FAIL raw_no_bypass: got raw=%b issue=%b exp raw=1 issue=0", sb.stall_raw, sb.issue); end
    @(negedge clk); set_wb(0, 0, 5'd0); #1;
    total++; if (sb.stall_raw !== 1'b0 || sb.issue !== 1'b1) begin bad++; $display("FAIL raw_release: got raw=%b issue=%b exp raw=0 issue=1", sb.stall_raw, sb.issue); end
    @(negedge clk); idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      instr(5'd0, 5'd0, 5'd3, 1'b0); #1;
      total++; if (sb.issue !== 1'b1) begin bad++; $display("FAIL sat_fill_issue%0d: got=%b exp=1", i, sb.issue); end
      @(negedge clk);
    end
    #1;
    total++; if (sb.stall_sat !== 1'b1 || sb.issue !== 1'b0) begin bad++; $display("FAIL sat_stall: got sat=%b issue=%b exp sat=1 issue=0", sb.stall_sat, sb.issue); end
    total++; if (sb.inflight_cnt !== 2'd3) begin bad++; $display("FAIL sat_inflight: got=%0d exp=3", sb.inflight_cnt); end
    @(negedge clk); set_wb(1, 1, 5'd3); #1;
    total++; if (sb.stall_sat !== 1'b1) begin bad++; $display("FAIL sat_retire_cycle: got=%b exp=1", sb.stall_sat); end
    @(negedge clk); set_wb(0, 0, 5'd0); #1;
    total++; if (sb.stall_sat !== 1'b0 || sb.issue !== 1'b1) begin bad++; $display("FAIL sat_release: got sat=%b issue=%b exp sat=0 issue=1", sb.stall_sat, sb.issue); end
    total++; if (sb.inflight_cnt !== 2'd2) begin bad++; $display("FAIL sat_inflight_after: got=%0d exp=2", sb.inflight_cnt); end
    @(negedge clk); idle();
  endtask

  task automatic test_serialize();
    do_reset();
    instr(5'd0, 5'd0, 5'd1, 1'b0); @(negedge clk);
    instr(5'd0, 5'd0, 5'd2, 1'b0); @(negedge clk);
    instr(5'd0, 5'd0, 5'd4, 1'b1); #1;
    total++; if (sb.stall_ser !== 1'b1 || sb.inflight_cnt !== 2'd2) begin bad++; $display("FAIL ser_enter_drain: got ser=%b infl=%0d exp ser=1 infl=2", sb.stall_ser, sb.inflight_cnt); end
    @(negedge clk); set_wb(1, 1, 5'd1); #1;
    total++; if (sb.stall_ser !== 1'b1 || sb.id_ready_go !== 1'b0) begin bad++; $display("FAIL ser_drain1: got ser=%b rdy=%b exp ser=1 rdy=0", sb.stall_ser, sb.id_ready_go); end
    @(negedge clk); set_wb(1, 1, 5'd2); #1;
    total++; if (sb.stall_ser !== 1'b1) begin bad++; $display("FAIL ser_drain2: got=%b exp=1", sb.stall_ser); end
    @(negedge clk); set_wb(0, 0, 5'd0); #1;
    total++; if (sb.stall_ser !== 1'b0 || sb.issue !== 1'b1) begin bad++; $display("FAIL ser_issue: got ser=%b issue=%b exp ser=0 issue=1", sb.stall_ser, sb.issue); end
    @(negedge clk); instr(5'd0, 5'd0, 5'd7, 1'b0); #1;
    total++; if (sb.stall_ser !== 1'b1 || sb.issue !== 1'b0) begin bad++; $display("FAIL ser_wait: got ser=%b issue=%b exp ser=1 issue=0", sb.stall_ser, sb.issue); end
    @(negedge clk); set_wb(1, 1, 5'd4); #1;
    total++; if (sb.stall_ser !== 1'b1) begin bad++; $display("FAIL ser_wait_retire: got=%b exp=1", sb.stall_ser); end
    @(negedge clk); set_wb(0, 0, 5'd0); #1;
    total++; if (sb.stall_ser !== 1'b0 || sb.issue !== 1'b1 || sb.inflight_cnt !== 2'd0) begin bad++; $display("FAIL ser_resume: got ser=%b issue=%b infl=%0d exp 0 1 0", sb.stall_ser, sb.issue, sb.inflight_cnt); end
    @(negedge clk); idle();
  endtask

  task automatic test_flush_all();
    do_reset();
    instr(5'd0, 5'd0, 5'd8, 1'b0); @(negedge clk);
    instr(5'd0, 5'd0, 5'd8, 1'b1); @(negedge clk);
    set_wb(1, 0, 5'd0); @(negedge clk);
    set_wb(0, 0, 5'd0); #1;
    total++; if (sb.issue !== 1'b1) begin bad++; $display("FAIL flush_ser_issue: got=%b exp=1", sb.issue); end
    @(negedge clk); instr(5'd8, 5'd0, 5'd9, 1'b0); #1;
    total++; if (sb.stall_ser !== 1'b1) begin bad++; $display("FAIL flush_in_serw: got=%b exp=1", sb.stall_ser); end
    sb.flush_all = 1; @(negedge clk); sb.flush_all = 0; #1;
    total++; if (sb.id_ready_go !== 1'b1 || sb.stall_raw !== 1'b0 || sb.issue !== 1'b1) begin bad++; $display("FAIL flush_cleared: got rdy=%b raw=%b issue=%b exp 1 0 1", sb.id_ready_go, sb.stall_raw, sb.issue); end
    total++; if (sb.inflight_cnt !== 2'd0 || sb.sb_err !== 1'b0) begin bad++; $display("FAIL flush_state: got infl=%0d err=%b exp 0 0", sb.inflight_cnt, sb.sb_err); end
    @(negedge clk); instr(5'd0, 5'd0, 5'd12, 1'b0); sb.flush_all = 1; #1;
    total++; if (sb.issue !== 1'b0 || sb.id_ready_go !== 1'b1) begin bad++; $display("FAIL flush_suppress: got issue=%b rdy=%b exp 0 1", sb.issue, sb.id_ready_go); end
    @(negedge clk); sb.flush_all = 0; instr(5'd12, 5'd0, 5'd0, 1'b0); #1;
    total++; if (sb.inflight_cnt !== 2'd0 || sb.stall_raw !== 1'b0) begin bad++; $display("FAIL flush_no_issue: got infl=%0d raw=%b exp 0 0", sb.inflight_cnt, sb.stall_raw); end
    @(negedge clk); idle();
  endtask

  task automatic test_same_cycle_err();
    do_reset();
    instr(5'd0, 5'd0, 5'd9, 1'b0); @(negedge clk);
    set_wb(1, 1, 5'd9); #1;
    total++; if (sb.issue !== 1'b1) begin bad++; $display("FAIL same_issue: got=%b exp=1", sb.issue); end
    @(negedge clk); set_wb(0, 0, 5'd0); instr(5'd9, 5'd0, 5'd0, 1'b0); #1;
    total++; if (sb.stall_raw !== 1'b1 || sb.inflight_cnt !== 2'd1) begin bad++; $display("FAIL same_pend_kept: got raw=%b infl=%0d exp 1 1", sb.stall_raw, sb.inflight_cnt); end
    @(negedge clk); set_wb(1, 1, 5'd9); #1;
    @(negedge clk); set_wb(0, 0, 5'd0); #1;
    total++; if (sb.stall_raw !== 1'b0 || sb.issue !== 1'b1 || sb.sb_err !== 1'b0) begin bad++; $display("FAIL same_one_retire: got raw=%b issue=%b err=%b exp 0 1 0", sb.stall_raw, sb.issue, sb.sb_err); end
    @(negedge clk); idle(); set_wb(1, 1, 5'd10); #1;
    total++; if (sb.sb_err !== 1'b0) begin bad++; $display("FAIL err_before_edge: got=%b exp=0", sb.sb_err); end
    @(negedge clk); set_wb(0, 0, 5'd0); instr(5'd10, 5'd0, 5'd10, 1'b0); #1;
    total++; if (sb.sb_err !== 1'b1 || sb.stall_raw !== 1'b0 || sb.inflight_cnt !== 2'd0) begin bad++; $display("FAIL err_set: got err=%b raw=%b infl=%0d exp 1 0 0", sb.sb_err, sb.stall_raw, sb.inflight_cnt); end
    @(negedge clk); idle(); #1;
    total++; if (sb.sb_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got=%b exp=1", sb.sb_err); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_wb(1, 1, 5'd10); @(negedge clk); set_wb(0, 0, 5'd0);
    instr(5'd0, 5'd0, 5'd5, 1'b0); @(negedge clk);
    instr(5'd5, 5'd0, 5'd6, 1'b0); #1;
    total++; if (sb.stall_raw !== 1'b1 || sb.sb_err !== 1'b1) begin bad++; $display("FAIL arst_pre: got raw=%b err=%b exp 1 1", sb.stall_raw, sb.sb_err); end
    #2 rst = 0; #1;
    total++; if (sb.stall_raw !== 1'b0 || sb.id_ready_go !== 1'b1 || sb.issue !== 1'b1) begin bad++; $display("FAIL arst_out: got raw=%b rdy=%b issue=%b exp 0 1 1", sb.stall_raw, sb.id_ready_go, sb.issue); end
    total++; if (sb.inflight_cnt !== 2'd0 || sb.sb_err !== 1'b0) begin bad++; $display("FAIL arst_state: got infl=%0d err=%b exp 0 0", sb.inflight_cnt, sb.sb_err); end
    @(negedge clk); rst = 1; idle();
  endtask

  typedef struct packed { logic wen; logic [4:0] rd; logic ser; } ent_t;

  task automatic test_random();
    ent_t q[$];
    logic have = 0, drain = 0;
    logic c_r1e, c_r2e, c_rde, c_ser;
    logic [4:0] c_r1, c_r2, c_rd;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int infl, n1, n2, nd;
      logic serw, e_raw, e_sat, e_ser, e_rdy, e_iss, alw, idf, fla, wbv;
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1;
        c_r1e = 1'($urandom_range(0, 1)); c_r1 = 5'($urandom_range(0, 4));
        c_r2e = 1'($urandom_range(0, 1)); c_r2 = 5'($urandom_range(0, 4));
        c_rde = 1'($urandom_range(0, 1)); c_rd = 5'($urandom_range(0, 4));
        c_ser = ($urandom_range(0, 7) == 0);
      end
      sb.id_valid = have;
      sb.rs1_r_ena = c_r1e; sb.rs1_r_addr = c_r1; sb.rs2_r_ena = c_r2e; sb.rs2_r_addr = c_r2;
      sb.rd_w_ena = c_rde; sb.rd_w_addr = c_rd; sb.ser_inst = c_ser;
      alw = ($urandom_range(0, 7) != 0); idf = ($urandom_range(0, 15) == 0); fla = ($urandom_range(0, 31) == 0);
      sb.ex_allowin = alw; sb.id_flush = idf; sb.flush_all = fla;
      wbv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      if (wbv) set_wb(1, q[0].wen, q[0].rd); else set_wb(0, 0, 5'd0);
      infl = q.size(); serw = 0; n1 = 0; n2 = 0; nd = 0;
      foreach (q[k]) begin
        if (q[k].ser) serw = 1;
        if (q[k].wen && q[k].rd == c_r1) n1++;
        if (q[k].wen && q[k].rd == c_r2) n2++;
        if (q[k].wen && q[k].rd == c_rd) nd++;
      end
      e_ser = serw || ((drain || (have && c_ser)) && infl != 0);
      e_raw = !e_ser && ((c_r1e && c_r1 != 0 && n1 > 0) || (c_r2e && c_r2 != 0 && n2 > 0));
      e_sat = !e_ser && !e_raw && ((c_rde && c_rd != 0 && nd == 3) || infl == 3);
      e_rdy = !(e_ser || e_raw || e_sat);
      e_iss = have && e_rdy && alw && !idf && !fla;
      #1;
      total++; if (sb.id_ready_go !== e_rdy) begin bad++; $display("FAIL rnd_ready c%0d: got=%b exp=%b", cyc, sb.id_ready_go, e_rdy); end
      total++; if (sb.issue !== e_iss) begin bad++; $display("FAIL rnd_issue c%0d: got=%b exp=%b", cyc, sb.issue, e_iss); end
      total++; if ({sb.stall_ser, sb.stall_raw, sb.stall_sat} !== {e_ser, e_raw, e_sat}) begin bad++; $display("FAIL rnd_stalls c%0d: got=%b exp=%b", cyc, {sb.stall_ser, sb.stall_raw, sb.stall_sat}, {e_ser, e_raw, e_sat}); end
      total++; if (sb.inflight_cnt !== 2'(infl)) begin bad++; $display("FAIL rnd_inflight c%0d: got=%0d exp=%0d", cyc, sb.inflight_cnt, infl); end
      total++; if (sb.sb_err !== 1'b0) begin bad++; $display("FAIL rnd_err c%0d: got=%b exp=0", cyc, sb.sb_err); end
      if (fla) begin
        q.delete(); drain = 0; have = 0;
      end else begin
        if (drain) begin
          if (idf || e_iss) drain = 0;
        end else if (!serw && have && c_ser && infl != 0 && !idf) begin
          drain = 1;
        end
        if (wbv) void'(q.pop_front());
        if (e_iss) q.push_back('{wen: c_rde, rd: c_rd, ser: c_ser});
        if (e_iss || idf) have = 0;
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_raw();
    test_saturation();
    test_serialize();
    test_flush_all();
    test_same_cycle_err();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
